// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration controller: FSM encoding,
// CORDIC mode codes and IEEE-754 single-precision helpers.
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

  localparam logic [1:0] MODE_LIN  = 2'b00;
  localparam logic [1:0] MODE_CIRC = 2'b01;
  localparam logic [1:0] MODE_HYP  = 2'b11;

  localparam int FP_SIGN_BIT = 31;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Conditionally negate a single-precision value by toggling its sign bit.
  function automatic logic [31:0] fp_flip_sign(input logic [31:0] v, input logic flip);
    return {v[FP_SIGN_BIT] ^ flip, v[FP_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Operand/result handshake between the iteration controller (master)
// and the floating-point CORDIC ALU (slave).
interface cordic_iter_ctrl_if;

  logic [31:0] Xi;
  logic [31:0] Yi;
  logic [31:0] Zi;
  logic [31:0] Ki;
  logic [31:0] deltai;
  logic [31:0] thetai;
  logic [31:0] ki;
  logic [1:0]  mode;
  logic        ALU_enable;
  logic        ALU_done;
  logic [31:0] X_next;
  logic [31:0] Y_next;
  logic [31:0] Z_next;
  logic [31:0] K_next;

  modport master (
    output Xi, Yi, Zi, Ki, deltai, thetai, ki, mode, ALU_enable,
    input  ALU_done, X_next, Y_next, Z_next, K_next
  );

  modport slave (
    input  Xi, Yi, Zi, Ki, deltai, thetai, ki, mode, ALU_enable,
    output ALU_done, X_next, Y_next, Z_next, K_next
  );

endinterface

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: walks the coefficient ROM, issues one ALU op per
// iteration and feeds results back. Optional ALU watchdog: CORDIC_CTRL_TIMEOUT_EN.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER      = 16,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode_in,
  input  logic [31:0]        X0,
  input  logic [31:0]        Y0,
  input  logic [31:0]        Z0,
  input  logic [31:0]        K0,
  output logic               busy,
  output logic               done,
  output logic [31:0]        X_out,
  output logic [31:0]        Y_out,
  output logic [31:0]        Z_out,
  output logic [31:0]        K_out,
  output logic [IDX_W-1:0]   rom_addr,
  input  logic [31:0]        rom_delta,
  input  logic [31:0]        rom_theta,
  input  logic [31:0]        rom_k,
`ifdef CORDIC_CTRL_TIMEOUT_EN
  output logic               err,
`endif
  cordic_iter_ctrl_if.master alu
);

  if (N_ITER < 1 || N_ITER > (2**IDX_W) - 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("cordic_iter_ctrl: N_ITER must be 1..2**IDX_W-1 and TIMEOUT_CYC >= 1");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      x_reg, y_reg, z_reg, k_reg;
  logic             done_q;
  logic             done_edge;

  // A done level still high from the previous op must not count as a new completion.
  assign done_edge = alu.ALU_done & ~done_q;

`ifdef CORDIC_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      x_reg          <= FP_ZERO;
      y_reg          <= FP_ZERO;
      z_reg          <= FP_ZERO;
      k_reg          <= FP_ZERO;
      done_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      X_out          <= FP_ZERO;
      Y_out          <= FP_ZERO;
      Z_out          <= FP_ZERO;
      K_out          <= FP_ZERO;
      rom_addr       <= '0;
      alu.Xi         <= FP_ZERO;
      alu.Yi         <= FP_ZERO;
      alu.Zi         <= FP_ZERO;
      alu.Ki         <= FP_ZERO;
      alu.deltai     <= FP_ZERO;
      alu.thetai     <= FP_ZERO;
      alu.ki         <= FP_ZERO;
      alu.mode       <= MODE_LIN;
      alu.ALU_enable <= 1'b0;
`ifdef CORDIC_CTRL_TIMEOUT_EN
      wait_cnt       <= '0;
      err            <= 1'b0;
`endif
    end else begin
      done_q         <= alu.ALU_done;
      alu.ALU_enable <= 1'b0;
      done           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_reg    <= X0;
            y_reg    <= Y0;
            z_reg    <= Z0;
            k_reg    <= K0;
            alu.mode <= mode_in;
            idx      <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
`ifdef CORDIC_CTRL_TIMEOUT_EN
            err      <= 1'b0;
`endif
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rom_addr <= idx;
          state    <= ST_LOAD;
        end
        // Rotation direction follows the sign of the residual angle Z.
        ST_LOAD: begin
          alu.Xi         <= x_reg;
          alu.Yi         <= y_reg;
          alu.Zi         <= z_reg;
          alu.Ki         <= k_reg;
          alu.deltai     <= fp_flip_sign(rom_delta, z_reg[FP_SIGN_BIT]);
          alu.thetai     <= fp_flip_sign(rom_theta, ~z_reg[FP_SIGN_BIT]);
          alu.ki         <= rom_k;
          alu.ALU_enable <= 1'b1;
          state          <= ST_ISSUE;
        end
        ST_ISSUE: begin
`ifdef CORDIC_CTRL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_edge) begin
            x_reg <= alu.X_next;
            y_reg <= alu.Y_next;
            z_reg <= alu.Z_next;
            k_reg <= alu.K_next;
            state <= ST_UPDATE;
          end
`ifdef CORDIC_CTRL_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            X_out <= x_reg;
            Y_out <= y_reg;
            Z_out <= z_reg;
            K_out <= k_reg;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_FIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        // Results are published on the way into FIN so they are valid with done.
        ST_UPDATE: begin
          if (idx == IDX_W'(N_ITER - 1)) begin
            X_out <= x_reg;
            Y_out <= y_reg;
            Z_out <= z_reg;
            K_out <= k_reg;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            idx      <= idx + 1'b1;
            rom_addr <= idx + 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Randomized bench for cordic_iter_ctrl: behavioural ROM and ALU models plus
// an iteration-level reference of the expected operand and result sequence.
module tb_cordic_iter_ctrl;
  import cordic_pkg::*;

  localparam int N     = 4;
  localparam int IDX_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode_in;
  logic [31:0]       X0, Y0, Z0, K0;
  logic              busy, done;
  logic [31:0]       X_out, Y_out, Z_out, K_out;
  logic [IDX_W-1:0]  rom_addr;
  logic [31:0]       rom_delta, rom_theta, rom_k;
`ifdef CORDIC_CTRL_TIMEOUT_EN
  logic              err;
`endif

  cordic_iter_ctrl_if alu ();

  cordic_iter_ctrl #(.N_ITER(N), .IDX_W(IDX_W), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
    .X0(X0), .Y0(Y0), .Z0(Z0), .K0(K0),
    .busy(busy), .done(done),
    .X_out(X_out), .Y_out(Y_out), .Z_out(Z_out), .K_out(K_out),
    .rom_addr(rom_addr), .rom_delta(rom_delta), .rom_theta(rom_theta), .rom_k(rom_k),
`ifdef CORDIC_CTRL_TIMEOUT_EN
    .err(err),
`endif
    .alu(alu)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Coefficient ROM: registered read, one cycle behind the address.
  logic [31:0] delta_tab [32];
  logic [31:0] theta_tab [32];
  logic [31:0] k_tab     [32];

  always @(posedge clk) begin
    rom_delta <= delta_tab[rom_addr];
    rom_theta <= theta_tab[rom_addr];
    rom_k     <= k_tab[rom_addr];
  end

  // Stand-in ALU arithmetic; any deterministic mix of all operands will do.
  function automatic logic [127:0] alu_fn(input logic [31:0] x, y, z, k, d, t, kk,
                                          input logic [1:0] m);
    logic [31:0] nx, ny, nz, nk;
    nx = x + (y ^ d);
    ny = y - (x ^ t);
    nz = (z + t) ^ (d << 1);
    nk = k ^ kk ^ {30'd0, m};
    return {nx, ny, nz, nk};
  endfunction

  // Expected per-iteration operands and final vector.
  logic [31:0] ex_x [N];
  logic [31:0] ex_y [N];
  logic [31:0] ex_z [N];
  logic [31:0] ex_k [N];
  logic [31:0] ex_d [N];
  logic [31:0] ex_t [N];
  logic [31:0] ex_kk[N];
  logic [1:0]  ex_mode;
  logic [31:0] fin_x, fin_y, fin_z, fin_k;

  task automatic build_model(input logic [31:0] x0, y0, z0, k0, input logic [1:0] m);
    logic [31:0] x, y, z, k, d, t;
    x = x0; y = y0; z = z0; k = k0;
    for (int i = 0; i < N; i++) begin
      d = delta_tab[i];
      t = theta_tab[i];
      if (z[31]) d = d ^ 32'h8000_0000;
      else       t = t ^ 32'h8000_0000;
      ex_x[i] = x; ex_y[i] = y; ex_z[i] = z; ex_k[i] = k;
      ex_d[i] = d; ex_t[i] = t; ex_kk[i] = k_tab[i];
      {x, y, z, k} = alu_fn(x, y, z, k, d, t, k_tab[i], m);
    end
    ex_mode = m;
    fin_x = x; fin_y = y; fin_z = z; fin_k = k;
  endtask

  // ALU model: latency lat cycles from enable to done, done held hold cycles.
  int          lat = 6;
  int          hold = 1;
  int          en_total, en_base = 0, rem, hold_left, last_en;
  logic [31:0] first_d, first_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu.ALU_done <= 1'b0;
      alu.X_next   <= '0;
      alu.Y_next   <= '0;
      alu.Z_next   <= '0;
      alu.K_next   <= '0;
      en_total     <= 0;
      rem          <= 0;
      hold_left    <= 0;
      last_en      <= 0;
    end else begin
      if (alu.ALU_done) begin
        if (hold_left <= 1) alu.ALU_done <= 1'b0;
        else begin
          hold_left  <= hold_left - 1;
          alu.X_next <= ~alu.X_next;
          alu.Y_next <= ~alu.Y_next;
          alu.Z_next <= ~alu.Z_next;
          alu.K_next <= ~alu.K_next;
        end
      end
      if (alu.ALU_enable) begin
        if ((en_total - en_base) < N) begin
          check_output("op_mode",   {30'd0, alu.mode}, {30'd0, ex_mode});
          check_output("op_Xi",     alu.Xi,     ex_x [en_total - en_base]);
          check_output("op_Yi",     alu.Yi,     ex_y [en_total - en_base]);
          check_output("op_Zi",     alu.Zi,     ex_z [en_total - en_base]);
          check_output("op_Ki",     alu.Ki,     ex_k [en_total - en_base]);
          check_output("op_deltai", alu.deltai, ex_d [en_total - en_base]);
          check_output("op_thetai", alu.thetai, ex_t [en_total - en_base]);
          check_output("op_ki",     alu.ki,     ex_kk[en_total - en_base]);
        end else begin
          check_output("extra_enable", en_total - en_base, N - 1);
        end
        if (en_total - en_base > 0)
          check_output("enable_spacing", cyc - last_en, 4 + lat);
        if (en_total == en_base) begin
          first_d <= alu.deltai;
          first_t <= alu.thetai;
        end
        {alu.X_next, alu.Y_next, alu.Z_next, alu.K_next} <=
          alu_fn(alu.Xi, alu.Yi, alu.Zi, alu.Ki, alu.deltai, alu.thetai, alu.ki, alu.mode);
        last_en  <= cyc;
        en_total <= en_total + 1;
        if (lat == 1) begin
          alu.ALU_done <= 1'b1;
          hold_left    <= hold;
        end else begin
          rem <= lat - 1;
        end
      end else if (rem > 0) begin
        if (rem == 1) begin
          alu.ALU_done <= 1'b1;
          hold_left    <= hold;
        end
        rem <= rem - 1;
      end
    end
  end

  int start_cyc;

  task automatic start_run(input logic [31:0] x0, y0, z0, k0, input logic [1:0] m,
                           input int l, input int h);
    lat  = l;
    hold = h;
    build_model(x0, y0, z0, k0, m);
    @(negedge clk);
    en_base   = en_total;
    start_cyc = cyc;
    start = 1'b1; mode_in = m;
    X0 = x0; Y0 = y0; Z0 = z0; K0 = k0;
    @(negedge clk);
    start = 1'b0;
    X0 = $urandom; Y0 = $urandom; Z0 = $urandom; K0 = $urandom;
  endtask

  task automatic finish_run(input string tag);
    int waited;
    repeat ($urandom_range(3, 12)) @(negedge clk);
    check_output({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
    start = 1'b1; mode_in = ~ex_mode; X0 = $urandom;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      check_output({tag, "_done_seen"}, 32'd0, 32'd1);
    end else begin
      check_output({tag, "_latency"}, cyc - start_cyc, N * (4 + lat) + 1);
      check_output({tag, "_enables"}, en_total - en_base, N);
      check_output({tag, "_X_out"}, X_out, fin_x);
      check_output({tag, "_Y_out"}, Y_out, fin_y);
      check_output({tag, "_Z_out"}, Z_out, fin_z);
      check_output({tag, "_K_out"}, K_out, fin_k);
      check_output({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check_output({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_output({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      check_output({tag, "_X_hold"}, X_out, fin_x);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] x0, y0, z0, k0,
                                input logic [1:0] m, input int l, input int h);
    start_run(x0, y0, z0, k0, m, l, h);
    finish_run(tag);
  endtask

  task automatic randomize_rom();
    for (int i = 0; i < 32; i++) begin
      delta_tab[i] = $urandom;
      theta_tab[i] = $urandom;
      k_tab[i]     = $urandom;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check_output({tag, "_done"},     {31'd0, done}, 32'd0);
    check_output({tag, "_enable"},   {31'd0, alu.ALU_enable}, 32'd0);
    check_output({tag, "_X_out"},    X_out, 32'd0);
    check_output({tag, "_K_out"},    K_out, 32'd0);
    check_output({tag, "_rom_addr"}, {27'd0, rom_addr}, 32'd0);
    check_output({tag, "_mode"},     {30'd0, alu.mode}, 32'd0);
    check_output({tag, "_Xi"},       alu.Xi, 32'd0);
    check_output({tag, "_deltai"},   alu.deltai, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [1:0] modes [3];
    int waited;
    modes[0] = MODE_LIN; modes[1] = MODE_CIRC; modes[2] = MODE_HYP;
    rst_n = 1'b0; start = 1'b0; mode_in = 2'b00;
    X0 = '0; Y0 = '0; Z0 = '0; K0 = '0;
    randomize_rom();
    delta_tab[0] = 32'h3F00_0000;
    theta_tab[0] = 32'h3EED_6338;
    #23;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("dir_pos", FP_ONE, FP_ZERO, 32'h3F00_0000, FP_ONE, MODE_CIRC, 6, 1);
    check_output("dir_pos_delta0", first_d, 32'h3F00_0000);
    check_output("dir_pos_theta0", first_t, 32'hBEED_6338);

    apply_stimulus("dir_neg", FP_ONE, FP_ZERO, 32'hBF00_0000, FP_ONE, MODE_HYP, 6, 2);
    check_output("dir_neg_delta0", first_d, 32'hBF00_0000);
    check_output("dir_neg_theta0", first_t, 32'h3EED_6338);

    for (int r = 0; r < 6; r++) begin
      randomize_rom();
      apply_stimulus("rand", $urandom, $urandom, $urandom, $urandom,
                     modes[$urandom_range(0, 2)], $urandom_range(1, 8), $urandom_range(1, 2));
    end

    // Abort a run while the third ALU op is outstanding.
    randomize_rom();
    start_run($urandom, $urandom, $urandom, $urandom, MODE_HYP, 6, 1);
    waited = 0;
    while ((en_total - en_base) < 3 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check_output("midrst_third_enable", en_total - en_base, 3);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("after_rst", $urandom, $urandom, $urandom, $urandom, MODE_CIRC, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
